sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 600, meaning clk cycles between refresh pulses (about 140 kHz at 84 MHz).
REQ-002 SHALL have parameter VID_DATA_DELAY, default 3, meaning cycles from mem_dtack rise to video data sample.
REQ-003 SHALL have parameter VID_RUN_MAX, default 4, meaning the maximum consecutive video grants while the CPU is pending.
REQ-004 SHALL have port clk, input, 1, the single clock shared with the SDRAM controller.
REQ-005 SHALL have port reset_n, input, 1, the reset; one clock, reset is synchronous and active-low.
REQ-006 SHALL have ports cpu_addr (in, 24, word address), cpu_din (in, 16), cpu_dout (out, 16), cpu_uds (in, 1), cpu_lds (in, 1), cpu_oe (in, 1), cpu_we (in, 1) and cpu_dtack (out, 1).
REQ-007 SHALL have ports vid_req (in, 1, level read request), vid_addr (in, 24), vid_data (out, 16) and vid_ack (out, 1, one-cycle pulse).
REQ-008 SHALL have ports mem_addr (out, 24), mem_din (out, 16), mem_dout (in, 16), mem_uds, mem_lds, mem_oe, mem_we (out, 1 each), mem_dtack (in, 1) and mem_refresh (out, 1, one-cycle pulse), connecting to the SDRAM controller port.

Function
REQ-009 SHALL implement the states IDLE, CPU, VID_RD, VID_DATA and RELEASE.
REQ-010 In IDLE with mem_dtack low, SHALL grant the video port if vid_req is high and vid_run < VID_RUN_MAX, otherwise the CPU port if cpu_oe or cpu_we is high, otherwise the video port if vid_req is high, otherwise remain in IDLE.
REQ-011 SHALL grant the CPU unconditionally when the CPU is pending and vid_run == VID_RUN_MAX.
REQ-012 vid_run SHALL increment on each video grant while the CPU is pending, saturating at VID_RUN_MAX, and SHALL clear on each CPU grant.
REQ-013 In CPU, mem_addr, mem_din, mem_uds, mem_lds, mem_oe and mem_we SHALL follow the cpu_* inputs combinationally.
REQ-014 In CPU, cpu_dtack SHALL equal mem_dtack and cpu_dout SHALL equal mem_dout.
REQ-015 SHALL leave CPU for RELEASE in the first cycle in which cpu_oe and cpu_we are both low.
REQ-016 A CPU write SHALL keep uds/lds passthrough after dtack, because the controller samples strobes late.
REQ-017 In VID_RD, SHALL drive mem_addr = vid_addr, which is latched at grant, with mem_oe = 1, mem_uds = mem_lds = 1 and mem_we = 0, until mem_dtack is seen high.
REQ-018 On the cycle after mem_dtack is seen high in VID_RD, SHALL drop mem_oe and enter VID_DATA.
REQ-019 VID_DATA SHALL count VID_DATA_DELAY cycles from the dtack-seen cycle, then register vid_data <= mem_dout, pulse vid_ack for one cycle and go to RELEASE.
REQ-020 RELEASE SHALL wait for mem_dtack low and then enter IDLE; no new grant is permitted while mem_dtack is high.
REQ-021 When the CPU is not granted, cpu_dtack SHALL be 0 and cpu_dout SHALL hold its last value.
REQ-022 When the port is not granted, all mem_* strobes SHALL be 0.
REQ-023 The refresh counter SHALL count 0..REFRESH_DIV-1, wrap to 0, and pulse mem_refresh at the wrap regardless of arbiter state.
REQ-024 If vid_req drops during VID_RD or VID_DATA, the transaction SHALL still complete and vid_ack SHALL still pulse.
REQ-025 If cpu_oe and vid_req rise in the same cycle with vid_run = 0, the video port SHALL win.

Reset
REQ-026 While reset_n is low at a clk edge, the state SHALL become IDLE and vid_run and the refresh counter SHALL become 0.
REQ-027 Under reset, vid_ack, mem_refresh and every mem_* strobe SHALL be 0, and cpu_dout and vid_data SHALL be 0x0000.
REQ-028 Reset during any grant SHALL abandon the transaction; the first grant after release SHALL still wait for mem_dtack low.

Structure
REQ-029 A shared package sdram_pkg SHALL hold the arbiter state enum and the REFRESH_DIV/VID_DATA_DELAY defaults.
REQ-030 The refresh divider SHALL be a sub-module, sdram_refresh_gen.

Verification
REQ-031 Idle bus, vid_req with vid_addr = 0x001234 -> mem_oe = 1 with mem_addr = 0x001234, and vid_ack with vid_data = model word exactly 3 cycles after mem_dtack rises.
REQ-032 CPU write 0xBEEF with lds only, strobes 2 cycles after we -> mem_uds = 0, mem_lds = 1 passthrough, and cpu_dtack equals mem_dtack.
REQ-033 vid_req held high and cpu_oe held high -> grant order V, V, V, V, C, V, ...
REQ-034 REFRESH_DIV = 600 -> mem_refresh pulses at cycles 599, 1199 and 1799 after reset release, including during grants.
REQ-035 Assert reset_n = 0 in the middle of VID_RD -> next cycle all strobes are 0 and no vid_ack occurs; the first grant after release waits for mem_dtack low.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM port arbiter: state encoding and parameter defaults.
package sdram_pkg;

  localparam int REFRESH_DIV_DEFAULT    = 600;
  localparam int VID_DATA_DELAY_DEFAULT = 3;
  localparam int VID_RUN_MAX_DEFAULT    = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CPU      = 3'd1,
    ST_VID_RD   = 3'd2,
    ST_VID_DATA = 3'd3,
    ST_RELEASE  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/sdram_refresh_gen.sv
// Free-running refresh divider: one-cycle pulse every REFRESH_DIV clocks.
module sdram_refresh_gen
  import sdram_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  output logic refresh
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Pulse coincides with the wrap so it is independent of arbiter activity.
  assign refresh = (cnt == LAST);

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port (CPU / video) arbiter in front of a single SDRAM controller port.
// Handshake: a grant owns the port until its transfer ends; a new grant is only issued while mem_dtack is low.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int REFRESH_DIV    = REFRESH_DIV_DEFAULT,
  parameter int VID_DATA_DELAY = VID_DATA_DELAY_DEFAULT,
  parameter int VID_RUN_MAX    = VID_RUN_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] cpu_addr,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  input  logic        cpu_uds,
  input  logic        cpu_lds,
  input  logic        cpu_oe,
  input  logic        cpu_we,
  output logic        cpu_dtack,
  input  logic        vid_req,
  input  logic [23:0] vid_addr,
  output logic [15:0] vid_data,
  output logic        vid_ack,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  output logic        mem_uds,
  output logic        mem_lds,
  output logic        mem_oe,
  output logic        mem_we,
  input  logic        mem_dtack,
  output logic        mem_refresh,
  output arb_state_t  arb_state
);

  localparam int RW = (VID_RUN_MAX > 0) ? $clog2(VID_RUN_MAX + 1) : 1;
  localparam int DW = (VID_DATA_DELAY > 1) ? $clog2(VID_DATA_DELAY + 1) : 1;
  localparam logic [RW-1:0] RUN_MAX  = RW'(VID_RUN_MAX);
  localparam logic [DW-1:0] DLY_LAST = DW'((VID_DATA_DELAY > 1) ? VID_DATA_DELAY - 1 : 0);

  arb_state_t    state;
  logic [RW-1:0] vid_run;
  logic [DW-1:0] dly_cnt;
  logic [23:0]   vid_addr_q;
  logic [15:0]   cpu_dout_q;
  logic          cpu_pending;

  assign cpu_pending = cpu_oe | cpu_we;
  assign arb_state   = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      vid_run    <= '0;
      dly_cnt    <= '0;
      vid_addr_q <= '0;
      cpu_dout_q <= '0;
      vid_data   <= '0;
      vid_ack    <= 1'b0;
    end else begin
      vid_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Video wins until it has used up its run while the CPU waits.
          if (!mem_dtack) begin
            if (vid_req && (vid_run < RUN_MAX)) begin
              state      <= ST_VID_RD;
              vid_addr_q <= vid_addr;
              if (cpu_pending) vid_run <= vid_run + 1'b1;
            end else if (cpu_pending) begin
              state   <= ST_CPU;
              vid_run <= '0;
            end else if (vid_req) begin
              state      <= ST_VID_RD;
              vid_addr_q <= vid_addr;
            end
          end
        end
        ST_CPU: begin
          cpu_dout_q <= mem_dout;
          if (!cpu_pending) state <= ST_RELEASE;
        end
        ST_VID_RD: begin
          if (mem_dtack) begin
            if (VID_DATA_DELAY <= 1) begin
              vid_data <= mem_dout;
              vid_ack  <= 1'b1;
              state    <= ST_RELEASE;
            end else begin
              dly_cnt <= DW'(1);
              state   <= ST_VID_DATA;
            end
          end
        end
        ST_VID_DATA: begin
          // The dtack-seen cycle already counted as the first delay cycle.
          if (dly_cnt == DLY_LAST) begin
            vid_data <= mem_dout;
            vid_ack  <= 1'b1;
            state    <= ST_RELEASE;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!mem_dtack) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr  = vid_addr_q;
    mem_din   = '0;
    mem_uds   = 1'b0;
    mem_lds   = 1'b0;
    mem_oe    = 1'b0;
    mem_we    = 1'b0;
    cpu_dtack = 1'b0;
    cpu_dout  = cpu_dout_q;
    case (state)
      ST_CPU: begin
        // Strobes stay transparent after dtack; the controller samples them late.
        mem_addr  = cpu_addr;
        mem_din   = cpu_din;
        mem_uds   = cpu_uds;
        mem_lds   = cpu_lds;
        mem_oe    = cpu_oe;
        mem_we    = cpu_we;
        cpu_dtack = mem_dtack;
        cpu_dout  = mem_dout;
      end
      ST_VID_RD: begin
        mem_oe  = 1'b1;
        mem_uds = 1'b1;
        mem_lds = 1'b1;
      end
      default: ;
    endcase
  end

  sdram_refresh_gen #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_refresh (
    .clk    (clk),
    .reset_n(reset_n),
    .refresh(mem_refresh)
  );

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small SDRAM controller responder (dtack after 2 cycles).
module tb_sdram_arbiter;
  import sdram_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [23:0] cpu_addr;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic        cpu_uds, cpu_lds, cpu_oe, cpu_we, cpu_dtack;
  logic        vid_req;
  logic [23:0] vid_addr;
  logic [15:0] vid_data;
  logic        vid_ack;
  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic        mem_uds, mem_lds, mem_oe, mem_we, mem_dtack, mem_refresh;
  arb_state_t  arb_state;

  logic        model_dtack;
  logic        force_dtack;
  int          lat_cnt;
  int          tests_run;
  int          tests_failed;

  sdram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .cpu_uds(cpu_uds), .cpu_lds(cpu_lds), .cpu_oe(cpu_oe), .cpu_we(cpu_we),
    .cpu_dtack(cpu_dtack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_ack(vid_ack),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_uds(mem_uds), .mem_lds(mem_lds), .mem_oe(mem_oe), .mem_we(mem_we),
    .mem_dtack(mem_dtack), .mem_refresh(mem_refresh), .arb_state(arb_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // controller responder: data word = addr[15:0] ^ 16'h5A5A
  assign mem_dtack = model_dtack | force_dtack;
  initial begin
    model_dtack = 1'b0;
    lat_cnt     = 0;
    mem_dout    = 16'h0000;
  end
  always @(posedge clk) begin
    #2;
    if (mem_oe || mem_we) begin
      if (lat_cnt < 2) lat_cnt++;
      if (lat_cnt >= 2) model_dtack = 1'b1;
    end else begin
      lat_cnt     = 0;
      model_dtack = 1'b0;
    end
    mem_dout = mem_addr[15:0] ^ 16'h5A5A;
  end

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (arb_state == ST_IDLE && !mem_dtack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (arb_state !== ST_IDLE) begin
      tests_failed++; $display("FAIL reset_state: got %0d expected %0d", arb_state, ST_IDLE);
    end
    tests_run++;
    if ({mem_oe, mem_we, mem_uds, mem_lds, mem_refresh, vid_ack, cpu_dtack} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_strobes: got %b expected 0000000",
               {mem_oe, mem_we, mem_uds, mem_lds, mem_refresh, vid_ack, cpu_dtack});
    end
    tests_run++;
    if (cpu_dout !== 16'h0000 || vid_data !== 16'h0000) begin
      tests_failed++; $display("FAIL reset_data: cpu_dout %h vid_data %h expected 0000", cpu_dout, vid_data);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_video_read();
    int d_at, a_at;
    bit ok;
    vid_addr = 24'h001234;
    vid_req  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_oe) begin ok = 1'b1; break; end
    end
    tests_run++;
    if (!ok || mem_addr !== 24'h001234 || {mem_uds, mem_lds, mem_we} !== 3'b110) begin
      tests_failed++;
      $display("FAIL vid_grant: oe %b addr %h uds/lds/we %b expected 1 001234 110",
               mem_oe, mem_addr, {mem_uds, mem_lds, mem_we});
    end
    // request drops and address changes while the read is in flight
    vid_req  = 1'b0;
    vid_addr = 24'hFFFFFF;
    #1;
    tests_run++;
    if (mem_addr !== 24'h001234) begin
      tests_failed++; $display("FAIL vid_addr_latch: got %h expected 001234", mem_addr);
    end
    d_at = -1;
    a_at = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (d_at >= 0 && i == d_at + 1) begin
        tests_run++;
        if (mem_oe !== 1'b0) begin
          tests_failed++; $display("FAIL vid_oe_drop: got %b expected 0", mem_oe);
        end
      end
      if (d_at < 0 && mem_dtack) d_at = i;
      if (vid_ack) begin a_at = i; break; end
    end
    tests_run++;
    if (d_at < 0 || a_at < 0 || (a_at - d_at) != 3) begin
      tests_failed++; $display("FAIL vid_ack_latency: got %0d expected 3 (dtack %0d ack %0d)", a_at - d_at, d_at, a_at);
    end
    tests_run++;
    if (vid_data !== 16'h486E) begin
      tests_failed++; $display("FAIL vid_data: got %h expected 486e", vid_data);
    end
    @(negedge clk);
    tests_run++;
    if (vid_ack !== 1'b0) begin
      tests_failed++; $display("FAIL vid_ack_pulse: got %b expected 0", vid_ack);
    end
    wait_idle(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL vid_release: got not idle expected idle");
    end
  endtask

  task automatic test_cpu_write();
    bit ok;
    cpu_addr = 24'h000456;
    cpu_din  = 16'hBEEF;
    cpu_uds  = 1'b0;
    cpu_lds  = 1'b0;
    cpu_we   = 1'b1;
    @(negedge clk);
    tests_run++;
    if (mem_we !== 1'b1 || mem_addr !== 24'h000456 || mem_din !== 16'hBEEF || cpu_dtack !== mem_dtack) begin
      tests_failed++;
      $display("FAIL cpu_wr_grant: we %b addr %h din %h dtack %b/%b expected 1 000456 beef equal",
               mem_we, mem_addr, mem_din, cpu_dtack, mem_dtack);
    end
    @(negedge clk);
    cpu_lds = 1'b1;
    #1;
    tests_run++;
    if (mem_uds !== 1'b0 || mem_lds !== 1'b1) begin
      tests_failed++; $display("FAIL cpu_wr_strobes: uds %b lds %b expected 0 1", mem_uds, mem_lds);
    end
    tests_run++;
    if (cpu_dtack !== 1'b1 || cpu_dtack !== mem_dtack) begin
      tests_failed++; $display("FAIL cpu_wr_dtack: got %b expected 1 (mem_dtack %b)", cpu_dtack, mem_dtack);
    end
    cpu_we  = 1'b0;
    cpu_lds = 1'b0;
    #1;
    tests_run++;
    if (mem_we !== 1'b0) begin
      tests_failed++; $display("FAIL cpu_wr_we_drop: got %b expected 0", mem_we);
    end
    @(negedge clk);
    tests_run++;
    if (cpu_dtack !== 1'b0) begin
      tests_failed++; $display("FAIL cpu_wr_release: dtack %b expected 0", cpu_dtack);
    end
    wait_idle(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL cpu_wr_idle: got not idle expected idle");
    end
  endtask

  task automatic test_cpu_read();
    bit ok;
    cpu_addr = 24'h000ABC;
    cpu_uds  = 1'b1;
    cpu_lds  = 1'b1;
    cpu_oe   = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cpu_dtack) begin ok = 1'b1; break; end
    end
    tests_run++;
    if (!ok || cpu_dout !== 16'h50E6) begin
      tests_failed++; $display("FAIL cpu_rd_data: dtack %b dout %h expected 1 50e6", ok, cpu_dout);
    end
    cpu_oe  = 1'b0;
    cpu_uds = 1'b0;
    cpu_lds = 1'b0;
    wait_idle(ok);
    tests_run++;
    if (!ok || cpu_dtack !== 1'b0 || cpu_dout !== 16'h50E6) begin
      tests_failed++; $display("FAIL cpu_rd_hold: dtack %b dout %h expected 0 50e6", cpu_dtack, cpu_dout);
    end
    tests_run++;
    if ({mem_oe, mem_we, mem_uds, mem_lds} !== 4'b0) begin
      tests_failed++; $display("FAIL idle_strobes: got %b expected 0000", {mem_oe, mem_we, mem_uds, mem_lds});
    end
  endtask

  task automatic test_grant_order();
    logic [7:0] got [11];
    string      exp_s;
    int         n;
    logic       prev_oe;
    bit         ok;
    exp_s = "VVVVCVVVVCV";
    for (int i = 0; i < 11; i++) got[i] = 8'h00;
    vid_addr = 24'h000100;
    cpu_addr = 24'h000200;
    cpu_uds  = 1'b1;
    cpu_lds  = 1'b1;
    vid_req  = 1'b1;
    cpu_oe   = 1'b1;
    n = 0;
    prev_oe = 1'b0;
    for (int c = 0; c < 800 && n < 11; c++) begin
      @(negedge clk);
      if (mem_oe && !prev_oe) begin
        got[n] = (mem_addr == 24'h000100) ? 8'h56 : ((mem_addr == 24'h000200) ? 8'h43 : 8'h3F);
        n++;
      end
      prev_oe = mem_oe;
      if (!cpu_oe) cpu_oe = 1'b1;
      else if (cpu_dtack) cpu_oe = 1'b0;
    end
    vid_req = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (cpu_dtack) begin cpu_oe = 1'b0; break; end
      if (!cpu_oe) cpu_oe = 1'b1;
    end
    cpu_oe = 1'b0;
    tests_run++;
    if (n != 11) begin
      tests_failed++; $display("FAIL grant_count: got %0d expected 11", n);
    end
    for (int i = 0; i < 11; i++) begin
      tests_run++;
      if (got[i] !== exp_s[i]) begin
        tests_failed++; $display("FAIL grant_order[%0d]: got %c expected %c", i, got[i], exp_s[i]);
      end
    end
    wait_idle(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL grant_order_idle: got not idle expected idle");
    end
  endtask

  task automatic test_refresh();
    int  pulse_at [4];
    int  np;
    bit  ok;
    for (int i = 0; i < 4; i++) pulse_at[i] = -1;
    np = 0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    vid_addr = 24'h000300;
    vid_req  = 1'b1;
    reset_n  = 1'b1;
    for (int c = 0; c < 1850; c++) begin
      if (mem_refresh) begin
        if (np < 4) pulse_at[np] = c;
        np++;
      end
      @(negedge clk);
    end
    vid_req = 1'b0;
    tests_run++;
    if (np != 3) begin
      tests_failed++; $display("FAIL refresh_count: got %0d expected 3", np);
    end
    tests_run++;
    if (pulse_at[0] != 599 || pulse_at[1] != 1199 || pulse_at[2] != 1799) begin
      tests_failed++;
      $display("FAIL refresh_cycles: got %0d %0d %0d expected 599 1199 1799", pulse_at[0], pulse_at[1], pulse_at[2]);
    end
    wait_idle(ok);
    tests_run++;
    if (!ok || vid_data !== 16'h595A) begin
      tests_failed++; $display("FAIL refresh_traffic: idle %b vid_data %h expected 1 595a", ok, vid_data);
    end
  endtask

  task automatic test_reset_mid_vid();
    bit ok;
    bit acked;
    vid_addr = 24'h000777;
    vid_req  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_oe) begin ok = 1'b1; break; end
    end
    reset_n     = 1'b0;
    force_dtack = 1'b1;
    @(negedge clk);
    tests_run++;
    if (!ok || {mem_oe, mem_we, mem_uds, mem_lds, vid_ack} !== 5'b0 || arb_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL rst_mid_strobes: granted %b strobes/ack %b state %0d expected 1 00000 0",
               ok, {mem_oe, mem_we, mem_uds, mem_lds, vid_ack}, arb_state);
    end
    tests_run++;
    if (vid_data !== 16'h0000 || cpu_dout !== 16'h0000) begin
      tests_failed++; $display("FAIL rst_mid_data: vid_data %h cpu_dout %h expected 0000", vid_data, cpu_dout);
    end
    @(negedge clk);
    reset_n = 1'b1;
    acked = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_oe) ok = 1'b0;
      if (vid_ack) acked = 1'b1;
    end
    tests_run++;
    if (!ok || acked) begin
      tests_failed++; $display("FAIL rst_wait_dtack: early grant %b ack %b expected 0 0", !ok, acked);
    end
    force_dtack = 1'b0;
    @(negedge clk);
    tests_run++;
    if (mem_oe !== 1'b1 || mem_addr !== 24'h000777) begin
      tests_failed++; $display("FAIL rst_regrant: oe %b addr %h expected 1 000777", mem_oe, mem_addr);
    end
    vid_req = 1'b0;
    acked = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (vid_ack) begin acked = 1'b1; break; end
    end
    tests_run++;
    if (!acked || vid_data !== 16'h5D2D) begin
      tests_failed++; $display("FAIL rst_regrant_data: ack %b data %h expected 1 5d2d", acked, vid_data);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    force_dtack  = 1'b0;
    cpu_addr     = '0;
    cpu_din      = '0;
    cpu_uds      = 1'b0;
    cpu_lds      = 1'b0;
    cpu_oe       = 1'b0;
    cpu_we       = 1'b0;
    vid_req      = 1'b0;
    vid_addr     = '0;
    @(negedge clk);
    test_reset();
    test_video_read();
    test_cpu_write();
    test_cpu_read();
    test_grant_order();
    test_refresh();
    test_reset_mid_vid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
